// File: rtl/param_srflop_counter.sv
// param_srflop_counter: modulo-N up/down counter gated by a set/reset run flop, with wrap tracking and a delayed stop.
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     sets the run flop; wins over stop and one-shot wrap
//   stop      clears the run flop
//   clear     synchronous clear of count and wrap_cnt
//   dir       0 = count up, 1 = count down
//   one_shot  clear the run flop on a wrap
//   count     current count, 0..MODULUS-1
//   cnt_en    run flop state
//   tc        one-cycle pulse after each wrap
//   wrap_cnt  saturating count of wraps
//   stop_dly  stop delayed by DELAY cycles
module param_srflop_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 14,
  parameter int DELAY   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             dir,
  input  logic             one_shot,
  output logic [WIDTH-1:0] count,
  output logic             cnt_en,
  output logic             tc,
  output logic [7:0]       wrap_cnt,
  output logic             stop_dly
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] count_q, count_d;
  logic             cnt_en_q, cnt_en_d;
  logic             tc_q, tc_d;
  logic [7:0]       wrap_cnt_q, wrap_cnt_d;
  logic [DELAY-1:0] dly_q, dly_d;
  logic             wrap;
  always_comb begin
    // clear suppresses the wrap so it can never raise tc or bump wrap_cnt
    wrap       = cnt_en_q && !clear && (dir ? count_q == '0 : count_q == MAX);
    count_d    = clear ? '0 : !cnt_en_q ? count_q : wrap ? (dir ? MAX : '0) : dir ? count_q - ONE : count_q + ONE;
    cnt_en_d   = start ? 1'b1 : stop ? 1'b0 : (wrap && one_shot) ? 1'b0 : cnt_en_q;
    tc_d       = wrap;
    wrap_cnt_d = clear ? '0 : (wrap && wrap_cnt_q != 8'hFF) ? wrap_cnt_q + 8'd1 : wrap_cnt_q;
    dly_d      = DELAY'({dly_q, stop});
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      cnt_en_q   <= 1'b0;
      tc_q       <= 1'b0;
      wrap_cnt_q <= '0;
      dly_q      <= '0;
    end else begin
      count_q    <= count_d;
      cnt_en_q   <= cnt_en_d;
      tc_q       <= tc_d;
      wrap_cnt_q <= wrap_cnt_d;
      dly_q      <= dly_d;
    end
  end
  assign count    = count_q;
  assign cnt_en   = cnt_en_q;
  assign tc       = tc_q;
  assign wrap_cnt = wrap_cnt_q;
  assign stop_dly = dly_q[DELAY-1];
endmodule

// File: tb/tb_param_srflop_counter.sv
// tb_param_srflop_counter: directed vector table plus hand sequences for param_srflop_counter.
module tb_param_srflop_counter;
  typedef struct {
    logic st, sp, cl, dr, os;
    logic [3:0] cnt;
    logic en, tc;
    logic [7:0] wc;
    logic sd;
  } vec_t;
  logic clk = 0, reset_n = 0;
  logic start = 0, stop = 0, clear = 0, dir = 0, one_shot = 0;
  logic [3:0] count;
  logic cnt_en, tc, stop_dly;
  logic [7:0] wrap_cnt;
  logic start2 = 0;
  logic [3:0] count2;
  logic cnt_en2, tc2, stop_dly2;
  logic [7:0] wrap_cnt2;
  int checks = 0, failures = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  param_srflop_counter dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear), .dir(dir),
    .one_shot(one_shot), .count(count), .cnt_en(cnt_en), .tc(tc), .wrap_cnt(wrap_cnt), .stop_dly(stop_dly)
  );
  param_srflop_counter #(.WIDTH(4), .MODULUS(16), .DELAY(2)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start2), .stop(1'b0), .clear(1'b0), .dir(1'b0),
    .one_shot(1'b0), .count(count2), .cnt_en(cnt_en2), .tc(tc2), .wrap_cnt(wrap_cnt2), .stop_dly(stop_dly2)
  );
  function automatic void add(logic st, sp, cl, dr, os, int cnt, logic en, tc_e, int wc, logic sd);
    vec_t v;
    v.st = st; v.sp = sp; v.cl = cl; v.dr = dr; v.os = os;
    v.cnt = 4'(cnt); v.en = en; v.tc = tc_e; v.wc = 8'(wc); v.sd = sd;
    tbl.push_back(v);
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] pack1();
    return {17'd0, count, cnt_en, tc, wrap_cnt, stop_dly};
  endfunction
  task automatic cyc(logic st, sp, cl, dr, os);
    start = st; stop = sp; clear = cl; dir = dr; one_shot = os;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int bad;
    int e, wraps;
    // up run, wrap 13->0, then stop and its delayed copy
    add(1,0,0,0,0, 0,1,0,0,0);
    for (int i = 1; i <= 16; i++) add(0,0,0,0,0, i % 14, 1, i == 14, (i >= 14) ? 1 : 0, 0);
    add(0,1,0,0,0, 3,0,0,1,0);
    add(0,0,0,0,0, 3,0,0,1,1);
    add(0,0,0,0,0, 3,0,0,1,0);
    add(0,0,1,0,0, 0,0,0,0,0);
    // down run from 0, start+stop together, direction change, clear at 13
    add(1,0,0,1,0, 0,1,0,0,0);
    add(0,0,0,1,0, 13,1,1,1,0);
    add(0,0,0,1,0, 12,1,0,1,0);
    add(0,0,0,1,0, 11,1,0,1,0);
    add(1,1,0,1,0, 10,1,0,1,0);
    add(0,0,0,1,0, 9,1,0,1,1);
    add(0,0,0,1,0, 8,1,0,1,0);
    for (int c = 9; c <= 13; c++) add(0,0,0,0,0, c,1,0,1,0);
    add(0,0,1,0,0, 0,1,0,0,0);
    add(0,0,0,0,0, 1,1,0,0,0);
    add(0,1,0,0,0, 2,0,0,0,0);
    add(0,0,0,0,0, 2,0,0,0,1);
    // one-shot run stops itself on wrap, restart resumes
    add(0,0,1,0,1, 0,0,0,0,0);
    add(1,0,0,0,1, 0,1,0,0,0);
    for (int i = 1; i <= 14; i++) add(0,0,0,0,1, i % 14, i < 14, i == 14, (i == 14) ? 1 : 0, 0);
    add(0,0,0,0,1, 0,0,0,1,0);
    add(1,0,0,0,1, 0,1,0,1,0);
    add(0,0,0,0,1, 1,1,0,1,0);
    #2;
    chk("reset_state", pack1(), 32'd0);
    chk("reset_state16", {19'd0, count2, cnt_en2, tc2, wrap_cnt2}, 32'd0);
    #10 reset_n = 1;
    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      cyc(tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].dr, tbl[i].os);
      chk($sformatf("vec%0d", i), pack1(), {17'd0, tbl[i].cnt, tbl[i].en, tbl[i].tc, tbl[i].wc, tbl[i].sd});
    end
    // asynchronous reset between edges while running
    cyc(0,1,0,0,0);
    #3 reset_n = 0;
    #1;
    chk("async_reset", pack1(), 32'd0);
    #2 reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(0,0,0,0,0);
      chk($sformatf("idle_after_reset%0d", i), {30'd0, count == 4'd0, cnt_en}, 32'd2);
    end
    cyc(1,0,0,0,0);
    chk("start_latency", pack1(), {17'd0, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0});
    cyc(0,0,0,0,0);
    chk("first_step", pack1(), {17'd0, 4'd1, 1'b1, 1'b0, 8'd0, 1'b0});
    // full-range modulus: 300 wraps, wrap_cnt saturates
    start2 = 1;
    @(posedge clk);
    #1;
    start2 = 0;
    chk("m16_start", {27'd0, count2, cnt_en2}, {27'd0, 4'd0, 1'b1});
    bad = 0; e = 0; wraps = 0;
    for (int i = 1; i <= 4800; i++) begin
      @(posedge clk);
      #1;
      e = (e + 1) % 16;
      if (e == 0) wraps++;
      if (count2 !== 4'(e) || tc2 !== (e == 0) || wrap_cnt2 !== 8'((wraps > 255) ? 255 : wraps)) bad++;
      if (i == 15) chk("m16_top", {28'd0, count2}, 32'd15);
      if (i == 16) chk("m16_wrap", {19'd0, count2, tc2, wrap_cnt2}, {19'd0, 4'd0, 1'b1, 8'd1});
    end
    chk("m16_seq_errors", bad, 0);
    chk("m16_sat", {19'd0, count2, tc2, wrap_cnt2}, {19'd0, 4'd0, 1'b1, 8'd255});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
